// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared arbiter state encoding and default CPU bus widths
package mem_arb_pkg;
    typedef enum logic {S_IDLE, S_LOCKED} state_t;
    localparam int BUS_AW = 8;
    localparam int BUS_DW = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search from ptr upward, wrapping modulo N
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);
    logic [PW-1:0] c;
    // Scanning from farthest to nearest lets the nearest requester overwrite the result
    always_comb begin
        gnt = '0;
        idx = '0;
        c = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = PW'((int'(ptr) + k) % N);
            if (req[c]) begin
                gnt = '0;
                gnt[c] = 1'b1;
                idx = c;
            end
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin RAM arbiter with bounded locked bursts
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int AW        = BUS_AW,
    parameter int DW        = BUS_DW,
    parameter int MAX_BURST = 16,
    parameter int PW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic               mem_we,
    input  logic [DW-1:0]      mem_rdata,
    output logic [PW-1:0]      owner,
    output logic               locked
);
    localparam int CW = $clog2(MAX_BURST);
    state_t state, state_n;
    logic [PW-1:0] ptr, ptr_n, owner_n, pick_idx, idx;
    logic [NREQ-1:0] pick_gnt;
    logic [CW-1:0] count, count_n;
    logic xfer;
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction
    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req(req),
        .ptr(ptr),
        .gnt(pick_gnt),
        .idx(pick_idx)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            ptr    <= '0;
            owner  <= '0;
            count  <= '0;
            rvalid <= '0;
            locked <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            owner  <= owner_n;
            count  <= count_n;
            rvalid <= (xfer && !we[idx]) ? gnt : '0;
            locked <= state_n == S_LOCKED;
        end
    end
    // Burst count runs every locked cycle so an idle owner cannot hog the bus
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        count_n = count;
        if (state == S_IDLE) begin
            if (xfer) begin
                ptr_n = wrap_inc(idx);
                if (lock[idx]) begin
                    state_n = S_LOCKED;
                    owner_n = idx;
                    count_n = '0;
                end
            end
        end else begin
            count_n = count + 1'b1;
            if ((xfer && !lock[owner]) || count == CW'(MAX_BURST - 1)) begin
                state_n = S_IDLE;
                ptr_n   = wrap_inc(owner);
                owner_n = '0;
                count_n = '0;
            end
        end
    end
    // Grants only ever go to requesting masters, so any grant bit means a transfer
    always_comb begin
        idx       = (state == S_LOCKED) ? owner : pick_idx;
        gnt       = reset ? '0 : (state == S_LOCKED) ? (NREQ'(req[owner]) << owner) : pick_gnt;
        xfer      = |gnt;
        mem_addr  = xfer ? addr[idx*AW +: AW] : '0;
        mem_wdata = xfer ? wdata[idx*DW +: DW] : '0;
        mem_we    = xfer & we[idx];
        rdata     = mem_rdata;
    end
endmodule
